// File: rtl/reduce_job_if.sv
// Requester and result handshake bundle for the reduce job arbiter.
// The master drives words and result accept; the slave is the arbiter.
interface reduce_job_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_sum;
  logic                  out_ovf;
  logic [IDW-1:0]        out_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_sum,
    input  out_ovf, out_id, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_sum,
    output out_ovf, out_id, busy
  );
endinterface

// File: rtl/reduce_job_arbiter.sv
// Round-robin scheduler sharing one accumulate datapath between requesters.
// Each granted job sums N words and returns the sum with the owner id.
module reduce_job_arbiter #(
  parameter int NREQ  = 4,
  parameter int N     = 32,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  reduce_job_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT
  } state_t;

  state_t           state;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   last_grant;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [CW-1:0]    cnt;
  logic [NREQ-1:0]  ready_q;
  logic             valid_q;
  logic             busy_q;

  logic [IDW-1:0]   pick;
  logic             found;
  logic [WIDTH-1:0] word;
  logic [WIDTH:0]   sum_c;
  logic             beat;
  logic             last_beat;

  // Search starts just after the last owner so every waiter gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      int j;
      j = (int'(last_grant) + i) % NREQ;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
  end

  assign word      = bus.req_data[int'(grant)*WIDTH +: WIDTH];
  assign sum_c     = {1'b0, acc} + {1'b0, word};
  assign beat      = (state == ACCUM) && bus.req_valid[grant];
  assign last_beat = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDW'(NREQ - 1);
      acc        <= '0;
      ovf        <= 1'b0;
      cnt        <= '0;
      ready_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant   <= pick;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            ready_q <= NREQ'(1) << pick;
            busy_q  <= 1'b1;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= sum_c[WIDTH-1:0];
            ovf <= ovf | sum_c[WIDTH];
            cnt <= cnt + CW'(1);
            if (last_beat) begin
              ready_q <= '0;
              valid_q <= 1'b1;
              state   <= RESULT;
            end
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign bus.out_id    = grant;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_reduce_job_arbiter.sv
// Directed bench for reduce_job_arbiter with a transaction-level model
// checked every cycle plus hand-computed result expectations.
module tb_reduce_job_arbiter;
  localparam int NREQ  = 4;
  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reduce_job_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  reduce_job_arbiter #(.NREQ(NREQ), .N(N), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;

  bit [7:0]  wq [NREQ][$];
  bit [NREQ-1:0] hold;

  int       res_id  [$];
  int       res_sum [$];
  int       res_ovf [$];
  int       res_hs  [$];
  int       grant_cyc, beat0_cyc, ov_rise_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = (wq[i].size() != 0) && !hold[i];
      bus.req_data[i*WIDTH +: WIDTH] =
        (wq[i].size() != 0) ? wq[i][0] : 8'h00;
    end
  endtask

  // Requester side: a word leaves its queue once a beat was seen.
  initial begin
    logic [NREQ-1:0] fire;
    forever begin
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready & {NREQ{!reset}};
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (fire[i]) void'(wq[i].pop_front());
      drive();
    end
  end

  // Model: job ownership, running integer total, result delivery.
  int  m_ph   = 0;
  int  m_own  = 0;
  int  m_last = NREQ - 1;
  int  m_cnt  = 0;
  int  m_tot  = 0;
  bit  prev_ov = 1'b0;

  initial begin
    logic [NREQ-1:0] rv, rr;
    forever begin
      @(negedge clk);
      rv = bus.req_valid;
      rr = bus.req_ready;
      if (mon_on) begin
        chk("req_ready", rr,
            (m_ph == 1) ? (64'd1 << m_own) : 64'd0);
        chk("ready_onehot", 64'($countones(rr) <= 1), 1);
        chk("out_valid", bus.out_valid, 64'(m_ph == 2));
        chk("busy", bus.busy, 64'(m_ph != 0));
        if (m_ph == 2) begin
          chk("out_sum", bus.out_sum, 64'(m_tot % 256));
          chk("out_ovf", bus.out_ovf, 64'(m_tot >= 256));
          chk("out_id", bus.out_id, 64'(m_own));
        end
        if (bus.out_valid === 1'b1 && !prev_ov) ov_rise_cyc = cyc;
        prev_ov = (bus.out_valid === 1'b1);
      end
      if (reset) begin
        m_ph   = 0;
        m_last = NREQ - 1;
      end else begin
        case (m_ph)
          0: if (rv != 0) begin
            bit got;
            got = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
              int j;
              j = (m_last + k) % NREQ;
              if (!got && rv[j]) begin
                got   = 1'b1;
                m_own = j;
              end
            end
            m_tot = 0;
            m_cnt = 0;
            m_ph  = 1;
            grant_cyc = cyc;
          end
          1: if (rv[m_own]) begin
            if (m_cnt == 0) beat0_cyc = cyc;
            m_tot += int'(bus.req_data[m_own*WIDTH +: WIDTH]);
            m_cnt++;
            if (m_cnt == N) m_ph = 2;
          end
          2: if (bus.out_ready) begin
            res_id.push_back(int'(bus.out_id));
            res_sum.push_back(int'(bus.out_sum));
            res_ovf.push_back(int'(bus.out_ovf));
            res_hs.push_back(cyc);
            m_last = m_own;
            m_ph   = 0;
          end
          default: m_ph = 0;
        endcase
      end
    end
  end

  task automatic wait_res(int n, int budget);
    int k;
    k = 0;
    while (res_id.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("result_timeout", 64'(res_id.size() >= n), 1);
  endtask

  task automatic wait_q(int r, int left);
    int k;
    k = 0;
    while (wq[r].size() > left && k < 60) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("beat_timeout", 64'(wq[r].size() == left), 1);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_sum"}, bus.out_sum, 0);
    chk({tag, "_ovf"}, bus.out_ovf, 0);
    chk({tag, "_id"}, bus.out_id, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c;
    int exp_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    reset = 1'b1;
    hold  = '0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst");

    // Single job from requester 0, latency pinned.
    @(posedge clk);
    #2;
    foreach (wq[0][i]) ;
    for (int w = 1; w <= 4; w++) wq[0].push_back(8'(w));
    c = cyc;
    drive();
    wait_res(1, 50);
    chk("t1_sum", res_sum[0], 10);
    chk("t1_id", res_id[0], 0);
    chk("t1_ovf", res_ovf[0], 0);
    chk("t1_grant_cyc", grant_cyc, c);
    chk("t1_first_beat", beat0_cyc, c + 1);
    chk("t1_valid_cyc", ov_rise_cyc, c + 5);

    // All four requesters saturated, two jobs each.
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    base = res_id.size();
    for (int i = 0; i < NREQ; i++)
      for (int w = 0; w < 8; w++) wq[i].push_back(8'(i*8 + w + 1));
    drive();
    wait_res(base + 8, 400);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_order%0d", k), res_id[base+k], exp_ord[k]);
    chk("t2_sum0", res_sum[base], 10);
    chk("t2_sum1", res_sum[base+1], 42);

    // Carry out of an 8-bit sum, then a clean all-zero job.
    @(posedge clk);
    #2;
    base = res_id.size();
    wq[2].push_back(8'hFF);
    wq[2].push_back(8'h02);
    repeat (6) wq[2].push_back(8'h00);
    drive();
    wait_res(base + 2, 100);
    chk("t3_sum", res_sum[base], 8'h01);
    chk("t3_ovf", res_ovf[base], 1);
    chk("t3_id", res_id[base], 2);
    chk("t3_sum_z", res_sum[base+1], 0);
    chk("t3_ovf_z", res_ovf[base+1], 0);

    // Result back-pressured for five cycles.
    @(posedge clk);
    #2;
    base = res_id.size();
    bus.out_ready = 1'b0;
    for (int w = 5; w <= 8; w++) wq[3].push_back(8'(w));
    repeat (4) wq[1].push_back(8'h01);
    drive();
    c = 0;
    while (bus.out_valid !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t4_valid_seen", bus.out_valid, 1);
    c = cyc;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_sum", bus.out_sum, 26);
      chk("t4_hold_id", bus.out_id, 3);
      chk("t4_hold_ready", bus.req_ready, 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    wait_res(base + 2, 100);
    chk("t4_accept_cyc", res_hs[base], c + 5);
    chk("t4_sum2", res_sum[base+1], 4);
    chk("t4_id2", res_id[base+1], 1);

    // Owner stalls for three cycles while requester 1 waits.
    @(posedge clk);
    #2;
    base = res_id.size();
    for (int w = 1; w <= 4; w++) wq[0].push_back(8'(w*10));
    for (int w = 1; w <= 4; w++) wq[1].push_back(8'(w));
    drive();
    wait_q(0, 2);
    hold[0] = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_stall_ready", bus.req_ready, 4'b0001);
      chk("t5_stall_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #2 hold[0] = 1'b0;
    drive();
    wait_res(base + 2, 100);
    chk("t5_sum", res_sum[base], 100);
    chk("t5_id", res_id[base], 0);
    chk("t5_sum1", res_sum[base+1], 10);
    chk("t5_id1", res_id[base+1], 1);

    // Reset after two of four beats, then resubmit.
    @(posedge clk);
    #2;
    base = res_id.size();
    repeat (4) wq[2].push_back(8'd50);
    drive();
    wait_q(2, 2);
    hold[2] = 1'b1;
    drive();
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("t6_rst");
    @(posedge clk);
    #2;
    wq[2].delete();
    hold[2] = 1'b0;
    for (int w = 1; w <= 4; w++) wq[2].push_back(8'(w));
    drive();
    wait_res(base + 1, 60);
    chk("t6_sum", res_sum[base], 10);
    chk("t6_id", res_id[base], 2);
    chk("t6_ovf", res_ovf[base], 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
